// File: rtl/regfile_pkg.sv
// Shared defaults for the multi-port register file and its pending-write scoreboard.
// Holds default widths, the address-width derivation and the hard-wired zero register index.
// Pure declarations: no logic, no latency, no flow control.
package regfile_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int NREG_DEF      = 32;
  localparam int NREAD_DEF     = 2;
  localparam int PEND_W_DEF    = 2;
  localparam int DEBUG_REG_DEF = 4;
  localparam int ZERO_REG      = 0;

  // Address width for a register count; a single-entry file still gets one address bit.
  function automatic int addr_w(input int nreg);
    return (nreg <= 1) ? 1 : $clog2(nreg);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write counters: issue marks in-flight producers, writeback clears them.
// Outputs are combinational from the counters and this cycle's clears; counters update on posedge.
// Marks are refused (mark_ready low) while the addressed counter is saturated; clears never stall.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG   = NREG_DEF,
  parameter int NREAD  = NREAD_DEF,
  parameter int PEND_W = PEND_W_DEF,
  localparam int AW    = addr_w(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREAD*AW-1:0] raddr,
  input  logic                we0,
  input  logic [AW-1:0]       waddr0,
  input  logic                wclr0,
  input  logic                we1,
  input  logic [AW-1:0]       waddr1,
  input  logic                wclr1,
  input  logic                mark_valid,
  input  logic [AW-1:0]       mark_addr,
  output logic [NREAD-1:0]    rbusy,
  output logic                mark_ready,
  output logic                sb_err
);

  localparam logic [AW-1:0]     ZA      = AW'(ZERO_REG);
  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [PEND_W-1:0] cnt_q [NREG];
  logic [PEND_W-1:0] cnt_d [NREG];
  logic              sb_err_q, sb_err_d;
  logic              clr0, clr1, mark_acc;
  logic [PEND_W:0]   up, dn;
  logic [AW-1:0]     rd_a;

  // Number of clears landing on register a this cycle (0, 1 or 2).
  function automatic logic [PEND_W:0] clr_cnt(input logic [AW-1:0] a,
                                               input logic c0, input logic [AW-1:0] a0,
                                               input logic c1, input logic [AW-1:0] a1);
    return {{PEND_W{1'b0}}, (c0 && a0 == a)} + {{PEND_W{1'b0}}, (c1 && a1 == a)};
  endfunction

  assign clr0       = we0 && wclr0 && (waddr0 != ZA);
  assign clr1       = we1 && wclr1 && (waddr1 != ZA);
  assign mark_ready = (mark_addr == ZA) || (cnt_q[mark_addr] != CNT_MAX);
  assign mark_acc   = mark_valid && (mark_addr != ZA) && (cnt_q[mark_addr] != CNT_MAX);
  assign sb_err     = sb_err_q;

  // Next counter value per register: add accepted mark, subtract clears, floor at zero and flag it.
  always_comb begin
    sb_err_d = sb_err_q;
    up       = '0;
    dn       = '0;
    for (int r = 0; r < NREG; r++) begin
      up = {1'b0, cnt_q[r]} + {{PEND_W{1'b0}}, (mark_acc && mark_addr == AW'(r))};
      dn = clr_cnt(AW'(r), clr0, waddr0, clr1, waddr1);
      if (up < dn) begin
        cnt_d[r] = '0;
        sb_err_d = 1'b1;
      end else begin
        cnt_d[r] = PEND_W'(up - dn);
      end
    end
  end

  // A read source is busy if producers remain after this cycle's clears; same-cycle marks do not count.
  always_comb begin
    rbusy = '0;
    rd_a  = '0;
    for (int i = 0; i < NREAD; i++) begin
      rd_a     = raddr[i*AW +: AW];
      rbusy[i] = (rd_a != ZA) &&
                 ({1'b0, cnt_q[rd_a]} > clr_cnt(rd_a, clr0, waddr0, clr1, waddr1));
    end
  end

  // Counter array and sticky underflow flag; reset discards marks and clears of the reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      sb_err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      sb_err_q <= sb_err_d;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD combinational read ports with write-through bypass, two write ports.
// Read latency 0 (bypass included); writes land in the array on posedge. Optional scoreboard: REGFILE_SCOREBOARD_EN.
// No backpressure on reads or writes; only marks can be refused, via mark_ready from the scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NREG      = NREG_DEF,
  parameter int NREAD     = NREAD_DEF,
  parameter int PEND_W    = PEND_W_DEF,
  parameter int DEBUG_REG = DEBUG_REG_DEF,
  localparam int AW       = addr_w(NREG)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREAD*AW-1:0]     raddr,
  output logic [NREAD*DATA_W-1:0] rdata,
  output logic [NREAD-1:0]        rbusy,
  input  logic                    we0,
  input  logic [AW-1:0]           waddr0,
  input  logic [DATA_W-1:0]       wdata0,
  input  logic                    wclr0,
  input  logic                    we1,
  input  logic [AW-1:0]           waddr1,
  input  logic [DATA_W-1:0]       wdata1,
  input  logic                    wclr1,
  input  logic                    mark_valid,
  input  logic [AW-1:0]           mark_addr,
  output logic                    mark_ready,
  output logic                    sb_err,
  output logic [DATA_W-1:0]       debug_out
);

  localparam logic [AW-1:0] ZA = AW'(ZERO_REG);
  localparam logic [AW-1:0] DA = AW'(DEBUG_REG);

  logic [DATA_W-1:0] mem_q [NREG];
  logic [AW-1:0]     rd_a;

  // Storage: port 1 is applied after port 0 so it wins an address collision; register 0 never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) mem_q[r] <= '0;
    end else begin
      if (we0 && waddr0 != ZA) mem_q[waddr0] <= wdata0;
      if (we1 && waddr1 != ZA) mem_q[waddr1] <= wdata1;
    end
  end

  // Read muxes: zero register, then port 1 forward, then port 0 forward, then the array.
  always_comb begin
    rdata = '0;
    rd_a  = '0;
    for (int i = 0; i < NREAD; i++) begin
      rd_a = raddr[i*AW +: AW];
      if (rd_a == ZA)                   rdata[i*DATA_W +: DATA_W] = '0;
      else if (we1 && waddr1 == rd_a)   rdata[i*DATA_W +: DATA_W] = wdata1;
      else if (we0 && waddr0 == rd_a)   rdata[i*DATA_W +: DATA_W] = wdata0;
      else                              rdata[i*DATA_W +: DATA_W] = mem_q[rd_a];
    end
  end

  assign debug_out = mem_q[DA];

`ifdef REGFILE_SCOREBOARD_EN
  regfile_scoreboard #(
    .NREG   (NREG),
    .NREAD  (NREAD),
    .PEND_W (PEND_W)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .raddr      (raddr),
    .we0        (we0),
    .waddr0     (waddr0),
    .wclr0      (wclr0),
    .we1        (we1),
    .waddr1     (waddr1),
    .wclr1      (wclr1),
    .mark_valid (mark_valid),
    .mark_addr  (mark_addr),
    .rbusy      (rbusy),
    .mark_ready (mark_ready),
    .sb_err     (sb_err)
  );
`else
  // Without the scoreboard nothing is ever pending and every mark is accepted.
  logic unused_sb_inputs;
  assign unused_sb_inputs = ^{mark_valid, mark_addr, wclr0, wclr1, PEND_W[0]};
  assign rbusy      = '0;
  assign mark_ready = 1'b1;
  assign sb_err     = 1'b0;
`endif

endmodule
